// File: rtl/input_stream_router.sv
// input_stream_router: header-decoded stream demultiplexer with one shared payload bus.
//
// Each packet is a header beat followed by N payload beats. The header carries
// N in in_bits[LEN_BITS-1:0] and the destination index D in in_bits[LEN_BITS+7:LEN_BITS].
// Payload for a valid D is forwarded combinationally to consumer D. Payload for
// an out-of-range D is consumed and discarded. N=0 headers produce no payload phase.
//
// Ports:
//   clock, reset           : rising-edge clock; synchronous active-high reset
//   in_valid/in_ready/in_bits  : upstream beat handshake and data
//   out_valid/out_ready    : per-consumer handshake (NUM_OUT bits each)
//   out_bits               : payload data shared by every consumer
//   out_last               : per-consumer final payload beat flag
//   busy                   : high while a payload phase (FWD or DROP) is in progress
//   pkt_count, drop_count  : saturating statistics counters, present only when
//                            INPUT_STREAM_ROUTER_STATS_EN is defined
module input_stream_router #(
    parameter int DATA_BITS = 64,
    parameter int NUM_OUT   = 4,
    parameter int LEN_BITS  = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_BITS-1:0] in_bits,
    output logic [NUM_OUT-1:0]   out_valid,
    input  logic [NUM_OUT-1:0]   out_ready,
    output logic [DATA_BITS-1:0] out_bits,
    output logic [NUM_OUT-1:0]   out_last,
    output logic                 busy
`ifdef INPUT_STREAM_ROUTER_STATS_EN
    ,
    output logic [31:0]          pkt_count,
    output logic [31:0]          drop_count
`endif
);

    localparam int DW = $clog2(NUM_OUT);

    typedef enum logic [1:0] {IDLE, FWD, DROP} state_t;

    state_t              r_state, w_next;
    logic [LEN_BITS-1:0] r_count, w_count_nxt;
    logic [DW-1:0]       r_dest, w_dest_nxt;
    logic [LEN_BITS-1:0] w_hdr_len;
    logic [7:0]          w_hdr_dst;
    logic [NUM_OUT-1:0]  w_sel;
    logic                w_sel_ready;
    logic                w_hs;
    logic                w_last_beat;

    assign w_hdr_len   = in_bits[LEN_BITS-1:0];
    assign w_hdr_dst   = in_bits[LEN_BITS+7:LEN_BITS];
    assign w_sel       = NUM_OUT'(1) << r_dest;
    // Only the latched consumer's ready matters; the others are masked off.
    assign w_sel_ready = |(out_ready & w_sel);
    assign w_hs        = in_valid && in_ready;
    assign w_last_beat = r_count == LEN_BITS'(1);
    assign out_bits    = in_bits;
    // Outputs are gated by reset directly so they are quiet during the reset cycle itself.
    assign busy        = !reset && r_state != IDLE;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
            r_count <= '0;
            r_dest  <= '0;
        end else begin
            r_state <= w_next;
            r_count <= w_count_nxt;
            r_dest  <= w_dest_nxt;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_count_nxt = r_count;
        w_dest_nxt  = r_dest;
        in_ready    = 1'b0;
        out_valid   = '0;
        out_last    = '0;
        if (!reset) begin
            case (r_state)
                IDLE: begin
                    in_ready = 1'b1;
                    if (in_valid && w_hdr_len != '0) begin
                        w_count_nxt = w_hdr_len;
                        if (w_hdr_dst < 8'(NUM_OUT)) begin
                            w_next     = FWD;
                            w_dest_nxt = w_hdr_dst[DW-1:0];
                        end else begin
                            w_next = DROP;
                        end
                    end
                end
                FWD: begin
                    in_ready  = w_sel_ready;
                    out_valid = in_valid ? w_sel : '0;
                    out_last  = (in_valid && w_last_beat) ? w_sel : '0;
                    if (in_valid && w_sel_ready) begin
                        w_count_nxt = r_count - LEN_BITS'(1);
                        w_next      = w_last_beat ? IDLE : FWD;
                    end
                end
                DROP: begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        w_count_nxt = r_count - LEN_BITS'(1);
                        w_next      = w_last_beat ? IDLE : DROP;
                    end
                end
                default: w_next = IDLE;
            endcase
        end
    end

`ifdef INPUT_STREAM_ROUTER_STATS_EN
    logic [31:0] r_pkt_count, r_drop_count;
    logic        w_pkt_done, w_drop_hdr;

    assign w_pkt_done = r_state == FWD && w_hs && w_last_beat;
    assign w_drop_hdr = r_state == IDLE && w_hs && w_hdr_len != '0 && w_hdr_dst >= 8'(NUM_OUT);
    assign pkt_count  = r_pkt_count;
    assign drop_count = r_drop_count;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_pkt_count  <= '0;
            r_drop_count <= '0;
        end else begin
            if (w_pkt_done && r_pkt_count != '1)
                r_pkt_count <= r_pkt_count + 32'd1;
            if (w_drop_hdr && r_drop_count != '1)
                r_drop_count <= r_drop_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_input_stream_router.sv
// tb_input_stream_router: directed scoreboard bench for input_stream_router.
module tb_input_stream_router;

    typedef struct packed {
        logic [3:0]  vld;
        logic [3:0]  lst;
        logic [63:0] d;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, busy;
    logic [63:0] in_bits, out_bits;
    logic [3:0]  out_valid, out_ready, out_last;
`ifdef INPUT_STREAM_ROUTER_STATS_EN
    logic [31:0] pkt_count, drop_count;
`endif

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    input_stream_router #(.DATA_BITS(64), .NUM_OUT(4), .LEN_BITS(16)) dut (
        .clock(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_bits(in_bits), .out_valid(out_valid), .out_ready(out_ready),
        .out_bits(out_bits), .out_last(out_last), .busy(busy)
`ifdef INPUT_STREAM_ROUTER_STATS_EN
        , .pkt_count(pkt_count), .drop_count(drop_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [3:0] v, input logic [3:0] l, input logic [63:0] d);
        sb.push_back('{vld: v, lst: l, d: d});
    endtask

    // Drive one beat; optionally hold the selected consumer not-ready for
    // `stall` cycles (out_ready = ~smask) before letting it complete.
    task automatic beat(input logic [63:0] d, input int stall = 0, input logic [3:0] smask = 4'b0000);
        exp_t e;
        in_valid = 1'b1;
        in_bits  = d;
        for (int i = 0; i < stall; i++) begin
            out_ready = ~smask;
            @(negedge clk);
            chk("stall_in_ready", in_ready, 0);
            chk("stall_out_valid", out_valid, sb.size() != 0 ? sb[0].vld : 4'b0);
            chk("stall_out_bits", out_bits, d);
            @(posedge clk);
            #1;
        end
        out_ready = 4'b1111;
        @(negedge clk);
        e = sb.size() != 0 ? sb.pop_front() : '0;
        chk("in_ready", in_ready, 1);
        chk("out_valid", out_valid, e.vld);
        chk("out_last", out_last, e.lst);
        if (e.vld != 4'b0) chk("out_bits", out_bits, e.d);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic chk_busy(input string tag, input logic exp);
        @(negedge clk);
        chk(tag, busy, exp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b1;
        in_bits   = 64'h0000_0000_0001_0001;
        out_ready = 4'b1111;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_busy", busy, 0);
`ifdef INPUT_STREAM_ROUTER_STATS_EN
        chk("rst_pkt_count", pkt_count, 0);
        chk("rst_drop_count", drop_count, 0);
`endif
        @(posedge clk);
        #1;
        reset    = 1'b0;
        in_valid = 1'b0;

        // Basic forward: N=3, D=2
        push(4'b0000, 4'b0000, 64'h0);
        push(4'b0100, 4'b0000, 64'hA);
        push(4'b0100, 4'b0000, 64'hB);
        push(4'b0100, 4'b0100, 64'hC);
        beat(64'h0000_0000_0002_0003);
        beat(64'hA);
        beat(64'hB);
        beat(64'hC);
        chk_busy("fwd_back_idle", 0);

        // Backpressure on port 1 while the other ports stay ready
        push(4'b0000, 4'b0000, 64'h0);
        push(4'b0010, 4'b0000, 64'hA);
        push(4'b0010, 4'b0010, 64'hB);
        beat(64'h0000_0000_0001_0002);
        beat(64'hA, 5, 4'b0010);
        beat(64'hB);
        chk_busy("bp_back_idle", 0);

        // Drop: N=4, D=7
        push(4'b0000, 4'b0000, 64'h0);
        beat(64'h0000_0000_0007_0004);
        chk("drop_busy", busy, 1);
        for (int i = 0; i < 4; i++) begin
            push(4'b0000, 4'b0000, 64'h0);
            beat(64'hD0 + 64'(i));
        end
        chk_busy("drop_back_idle", 0);
`ifdef INPUT_STREAM_ROUTER_STATS_EN
        chk("drop_count", drop_count, 1);
        chk("pkt_count", pkt_count, 2);
`endif

        // Zero-length header then back-to-back N=1, D=3
        push(4'b0000, 4'b0000, 64'h0);
        push(4'b0000, 4'b0000, 64'h0);
        push(4'b1000, 4'b1000, 64'h55);
        beat(64'h0000_0000_0000_0000);
        chk("zero_len_busy", busy, 0);
        beat(64'h0000_0000_0003_0001);
        beat(64'h55);
        chk_busy("b2b_back_idle", 0);

        // Reset mid-packet: N=5, D=0, two beats, then reset
        push(4'b0000, 4'b0000, 64'h0);
        push(4'b0001, 4'b0000, 64'h11);
        push(4'b0001, 4'b0000, 64'h22);
        beat(64'h0000_0000_0000_0005);
        beat(64'h11);
        beat(64'h22);
        reset    = 1'b1;
        in_valid = 1'b1;
        in_bits  = 64'h33;
        @(negedge clk);
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_busy", busy, 0);
        @(posedge clk);
        #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        push(4'b0000, 4'b0000, 64'h0);
        push(4'b0010, 4'b0010, 64'h77);
        beat(64'h0000_0000_0001_0001);
        chk("post_rst_busy", busy, 1);
        beat(64'h77);
        chk_busy("post_rst_idle", 0);
        chk("sb_drained", 64'(sb.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
